// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   - FSM state encodings (also exported on the debug state port)
//   - Supported opcode constants
//   - ALU operation encodings
//   - op_supported(): true for the opcodes the controller can execute
package mips_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } ctrl_state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OpRtype, OpLw, OpSw, OpBeq, OpJ, OpAddi: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stall_timer.sv
// Counts consecutive memory-wait cycles and flags an abort on the limit cycle.
//   clk     in  clock
//   reset   in  synchronous active-high reset
//   active  in  controller is in a memory-access state (FETCH or MEM)
//   ready   in  memory completes this cycle
//   expired out this is the STALL_LIMIT-th consecutive not-ready cycle
module stall_timer #(
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic expired
);

    logic [7:0] count_q, count_d;

    // count_q holds the number of not-ready cycles already spent, so the
    // limit cycle is the one where it equals STALL_LIMIT-1.
    assign expired = active && !ready && (count_q == 8'(STALL_LIMIT - 1));

    // Any exit from the waiting condition (leaving the state, completing, or
    // aborting back to FETCH) starts the next access from zero.
    always_comb begin
        count_d = count_q;
        if (!active || ready || expired) begin
            count_d = '0;
        end else begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM (FETCH, DECODE, EXEC, MEM, WB).
//   clk, reset                  clock, synchronous active-high reset
//   opcode                      instruction opcode (sampled in DECODE)
//   flag_zero                   ALU zero flag (beq resolution in EXEC)
//   mem_ready                   memory completes this cycle (FETCH/MEM only)
//   pc_write/ir_write/reg_write register enables
//   mem_read/mem_write          memory strobes
//   alu_src/reg_dest/mem_to_reg/branch/jump  datapath selects
//   alu_op                      00 add, 01 sub, 10 funct-decoded
//   state                       current FSM state (debug)
//   instr_done                  one-cycle retire pulse
//   illegal_op/mem_timeout      sticky error flags, cleared only by reset
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       flag_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src,
    output logic       reg_dest,
    output logic       mem_to_reg,
    output logic       branch,
    output logic       jump,
    output logic [1:0] alu_op,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    ctrl_state_e state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic        mem_active;
    logic        expired;

    assign mem_active = (state_q == StFetch) || (state_q == StMem);

    stall_timer #(
        .STALL_LIMIT(STALL_LIMIT)
    ) u_stall_timer (
        .clk    (clk),
        .reset  (reset),
        .active (mem_active),
        .ready  (mem_ready),
        .expired(expired)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_dest   = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = AluAdd;
        instr_done = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    alu_op   = AluAdd;
                    state_d  = StDecode;
                end else if (expired) begin
                    // The strobe stays up through the limit cycle; the
                    // access is dropped by restarting the fetch.
                    timeout_d = 1'b1;
                    state_d   = StFetch;
                end
            end

            StDecode: begin
                op_d = opcode;
                if (op_supported(opcode)) begin
                    state_d = StExec;
                end else begin
                    illegal_d  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end

            StExec: begin
                case (op_q)
                    OpRtype: begin
                        alu_src = 1'b0;
                        alu_op  = AluFunct;
                        state_d = StWb;
                    end
                    OpLw, OpSw: begin
                        alu_src = 1'b1;
                        alu_op  = AluAdd;
                        state_d = StMem;
                    end
                    OpAddi: begin
                        alu_src = 1'b1;
                        alu_op  = AluAdd;
                        state_d = StWb;
                    end
                    OpBeq: begin
                        branch     = 1'b1;
                        alu_op     = AluSub;
                        pc_write   = flag_zero;
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end
                    OpJ: begin
                        jump       = 1'b1;
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end
                    default: state_d = StFetch;
                endcase
            end

            StMem: begin
                if (op_q == OpLw) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                end
                if (mem_ready) begin
                    if (op_q == OpLw) begin
                        state_d = StWb;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = StFetch;
                end
            end

            StWb: begin
                reg_write  = 1'b1;
                reg_dest   = (op_q == OpRtype);
                mem_to_reg = (op_q == OpLw);
                instr_done = 1'b1;
                state_d    = StFetch;
            end

            default: state_d = StFetch;
        endcase

        // Reset wins over whatever the current state would drive, so an
        // interrupted instruction has no side effects in the reset cycle.
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            alu_src    = 1'b0;
            reg_dest   = 1'b0;
            mem_to_reg = 1'b0;
            branch     = 1'b0;
            jump       = 1'b0;
            alu_op     = AluAdd;
            instr_done = 1'b0;
        end
    end

    assign state       = reset ? 3'd0 : state_q;
    assign illegal_op  = illegal_q && !reset;
    assign mem_timeout = timeout_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            op_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: each instruction is expanded into its
// expected per-cycle trace from the instruction-level rules, then replayed
// against the DUT one cycle at a time.
module tb_multicycle_ctrl;

    localparam int unsigned Limit = 4;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_timeout;
    } outs_t;

    typedef struct packed {
        logic       ready;
        logic       zero;
        logic [5:0] op;
        outs_t      exp;
    } step_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       flag_zero;
    logic       mem_ready;
    outs_t      act;

    multicycle_ctrl #(
        .STALL_LIMIT(Limit)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .flag_zero  (flag_zero),
        .mem_ready  (mem_ready),
        .pc_write   (act.pc_write),
        .ir_write   (act.ir_write),
        .reg_write  (act.reg_write),
        .mem_read   (act.mem_read),
        .mem_write  (act.mem_write),
        .alu_src    (act.alu_src),
        .reg_dest   (act.reg_dest),
        .mem_to_reg (act.mem_to_reg),
        .branch     (act.branch),
        .jump       (act.jump),
        .alu_op     (act.alu_op),
        .state      (act.state),
        .instr_done (act.instr_done),
        .illegal_op (act.illegal_op),
        .mem_timeout(act.mem_timeout)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    step_t trace[$];
    logic  m_illegal = 1'b0;
    logic  m_timeout = 1'b0;

    localparam logic [5:0] OR = 6'b000000, OLW = 6'b100011, OSW = 6'b101011;
    localparam logic [5:0] OBEQ = 6'b000100, OJ = 6'b000010, OADDI = 6'b001000;
    logic [5:0] legal_ops[6] = '{OR, OLW, OSW, OBEQ, OJ, OADDI};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input logic rdy, input logic z, input logic [5:0] op, input outs_t o);
        step_t s;
        o.illegal_op  = m_illegal;
        o.mem_timeout = m_timeout;
        s.ready = rdy;
        s.zero  = z;
        s.op    = op;
        s.exp   = o;
        trace.push_back(s);
    endtask

    // Expand one instruction into the cycles it should take. fw/mw are the
    // number of not-ready memory cycles before completion in FETCH/MEM; zf<0
    // means a random zero flag in EXEC.
    task automatic build_instr(input logic [5:0] op, input int fw, input int mw, input int zf);
        outs_t o;
        logic  z;
        for (int i = 0; i < fw && i < int'(Limit); i++) begin
            o = '0; o.state = 3'd0; o.mem_read = 1'b1;
            push(1'b0, rbit(), 6'($urandom), o);
            if (i == int'(Limit) - 1) begin
                m_timeout = 1'b1;
                return;
            end
        end
        o = '0; o.state = 3'd0; o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(1'b1, rbit(), 6'($urandom), o);

        o = '0; o.state = 3'd1;
        if (!is_legal(op)) o.instr_done = 1'b1;
        push(rbit(), rbit(), op, o);
        if (!is_legal(op)) begin
            m_illegal = 1'b1;
            return;
        end

        z = (zf < 0) ? rbit() : zf[0];
        o = '0; o.state = 3'd2;
        if (op == OR) o.alu_op = 2'b10;
        if (op == OLW || op == OSW || op == OADDI) o.alu_src = 1'b1;
        if (op == OBEQ) begin
            o.branch = 1'b1; o.alu_op = 2'b01; o.pc_write = z; o.instr_done = 1'b1;
        end
        if (op == OJ) begin
            o.jump = 1'b1; o.pc_write = 1'b1; o.instr_done = 1'b1;
        end
        push(rbit(), z, 6'($urandom), o);
        if (op == OBEQ || op == OJ) return;

        if (op == OLW || op == OSW) begin
            for (int i = 0; i < mw && i < int'(Limit); i++) begin
                o = '0; o.state = 3'd3;
                o.mem_read = (op == OLW); o.mem_write = (op == OSW);
                push(1'b0, rbit(), 6'($urandom), o);
                if (i == int'(Limit) - 1) begin
                    m_timeout = 1'b1;
                    return;
                end
            end
            o = '0; o.state = 3'd3;
            o.mem_read = (op == OLW); o.mem_write = (op == OSW); o.instr_done = (op == OSW);
            push(1'b1, rbit(), 6'($urandom), o);
            if (op == OSW) return;
        end

        o = '0; o.state = 3'd4; o.reg_write = 1'b1;
        o.reg_dest = (op == OR); o.mem_to_reg = (op == OLW); o.instr_done = 1'b1;
        push(rbit(), rbit(), 6'($urandom), o);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset = 1'b1; opcode = 6'($urandom); flag_zero = rbit(); mem_ready = rbit();
            @(negedge clk);
            check_eq("in_reset", 32'(act), 32'(outs_t'('0)));
            @(posedge clk); #1;
        end
        reset = 1'b0;
        m_illegal = 1'b0;
        m_timeout = 1'b0;
    endtask

    // Replay the queued trace; with reset_in_mem set, reset is asserted in
    // the first MEM cycle and the remainder of the instruction is dropped.
    task automatic run_trace(input string name, input bit reset_in_mem);
        step_t s;
        while (trace.size() > 0) begin
            s = trace.pop_front();
            opcode = s.op; flag_zero = s.zero; mem_ready = s.ready;
            if (reset_in_mem && s.exp.state == 3'd3) begin
                reset = 1'b1;
                @(negedge clk);
                check_eq({name, "_reset_in_mem"}, 32'(act), 32'(outs_t'('0)));
                @(posedge clk); #1;
                reset = 1'b0;
                m_illegal = 1'b0;
                m_timeout = 1'b0;
                trace.delete();
            end else begin
                reset = 1'b0;
                @(negedge clk);
                check_eq($sformatf("%s_st%0d", name, s.exp.state), 32'(act), 32'(s.exp));
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        reset = 1'b1; opcode = '0; flag_zero = 1'b0; mem_ready = 1'b0;
        do_reset(2);

        build_instr(OR, 0, 0, -1);    run_trace("rtype", 1'b0);
        build_instr(OLW, 2, 2, -1);   run_trace("lw_wait", 1'b0);
        build_instr(OBEQ, 0, 0, 1);   run_trace("beq_taken", 1'b0);
        build_instr(OBEQ, 0, 0, 0);   run_trace("beq_not", 1'b0);
        build_instr(OADDI, 1, 0, -1); run_trace("addi", 1'b0);
        build_instr(OJ, 0, 0, -1);    run_trace("jump", 1'b0);
        build_instr(6'h3f, 0, 0, -1); run_trace("illegal", 1'b0);
        build_instr(OSW, 0, 9, -1);   run_trace("sw_timeout", 1'b0);
        build_instr(OR, 9, 0, -1);    run_trace("fetch_timeout", 1'b0);
        build_instr(OSW, 3, 3, -1);   run_trace("sw_limit_ok", 1'b0);
        build_instr(OSW, 0, 2, -1);   run_trace("sw_reset", 1'b1);
        build_instr(OR, 0, 0, -1);    run_trace("after_reset", 1'b0);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            int fw, mw;
            if ($urandom_range(0, 15) == 0) do_reset(1);
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
            fw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
            mw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
            build_instr(op, fw, mw, -1);
            run_trace("rand", 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: STALL_LIMIT, 16, max consecutive cycles a memory access waits for mem_ready before abort (range 2..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 opcode  in  6  instruction opcode from instruction register.
REQ-005 flag_zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory completes the current read/write this cycle.
REQ-007 pc_write, ir_write, reg_write  out  1 each  register enables.
REQ-008 mem_read, mem_write  out  1 each  memory strobes.
REQ-009 alu_src, reg_dest, mem_to_reg, branch, jump  out  1 each  datapath mux selects.
REQ-010 alu_op  out  2  00 add, 01 subtract, 10 funct-decoded.
REQ-011 state  out  3  current FSM state, for debug.
REQ-012 instr_done  out  1  one-cycle pulse on instruction retirement.
REQ-013 illegal_op, mem_timeout  out  1 each  sticky error flags.

Function
REQ-014 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5..7 SHALL go to FETCH next cycle.
REQ-015 FETCH: mem_read=1; on mem_ready=1 assert ir_write=1, pc_write=1, alu_op=00 (PC+4), go to DECODE; else stay.
REQ-016 DECODE: latch opcode into internal op_q; unsupported opcode sets illegal_op, pulses instr_done, returns to FETCH.
REQ-017 Supported: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-018 EXEC R-type: alu_src=0, alu_op=10, go WB.
REQ-019 EXEC lw/sw/addi: alu_src=1, alu_op=00; lw/sw go MEM, addi goes WB.
REQ-020 EXEC beq: branch=1, alu_op=01, pc_write=flag_zero same cycle; pulse instr_done; go FETCH.
REQ-021 EXEC j: jump=1, pc_write=1; pulse instr_done; go FETCH.
REQ-022 MEM lw: mem_read=1 until mem_ready, then go WB; MEM sw: mem_write=1 until mem_ready, then pulse instr_done, go FETCH.
REQ-023 WB: reg_write=1; reg_dest=1 for R-type, else 0; mem_to_reg=1 for lw only; pulse instr_done; go FETCH.
REQ-024 Outputs not listed for a state SHALL be 0; outputs are combinational from state, op_q, flag_zero, mem_ready.
REQ-025 An 8-bit stall counter SHALL count consecutive FETCH/MEM cycles with mem_ready=0, clearing on any state change or mem_ready=1.
REQ-026 When the counter reaches STALL_LIMIT-1 with mem_ready=0: set mem_timeout, deassert strobes, go FETCH without pc_write or instr_done.
REQ-027 mem_ready=1 on the limit cycle SHALL complete normally and not set mem_timeout.
REQ-028 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-029 Latency: beq/j 3 cycles, R-type/addi/sw 4, lw 5, with zero wait states.

Reset
REQ-030 While reset=1 all outputs SHALL be 0 except state=0; next state FETCH; op_q, stall counter, illegal_op, mem_timeout cleared.
REQ-031 Reset mid-instruction SHALL abort it, producing no reg_write, mem_write, pc_write, or instr_done in that cycle.
REQ-032 Error flags SHALL clear only on reset.

Structure
REQ-033 Shared package mips_pkg SHALL hold opcode constants, state encodings, and alu_op encodings.
REQ-034 Stall counter and limit compare SHALL live in sub-module stall_timer (inputs clk, reset, active, ready; output expired).

Verification
REQ-035 Reset, then R-type with mem_ready=1 always -> states 0,1,2,4; reg_write=1, reg_dest=1 in cycle 4; instr_done pulse cycle 4.
REQ-036 lw, FETCH and MEM each 2 wait cycles -> 9 cycles total; mem_to_reg=1, reg_write=1 in WB only.
REQ-037 beq with flag_zero=1, then flag_zero=0 -> pc_write=1 in EXEC the first time, 0 the second; both retire in 3 cycles.
REQ-038 opcode 111111 -> illegal_op=1 after DECODE; back to FETCH; flag holds until reset.
REQ-039 STALL_LIMIT=4, sw with mem_ready=0 in MEM -> mem_write high exactly 4 cycles; mem_timeout=1; FETCH; no instr_done.
REQ-040 reset asserted during MEM of sw -> mem_write=0 that cycle; state=0 next cycle; flags 0.
